// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Handshake/bus bundle between the fetch stage and its
//                environment (hazard unit, decode, instruction memory).
//                  master : the fetch stage (drives im_addr and D_* outputs)
//                  slave  : the environment (drives control, redirect, im_rdata)
//  Signals     : stall, flush, redirect, redirect_pc  -> fetch
//                im_rdata                              -> fetch
//                im_addr, D_instr, D_pc, D_pc8,
//                D_valid, D_exc_adel                   <- fetch
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc8;
    logic        D_valid;
    logic        D_exc_adel;

    modport master (
        input  stall, flush, redirect, redirect_pc, im_rdata,
        output im_addr, D_instr, D_pc, D_pc8, D_valid, D_exc_adel
    );

    modport slave (
        output stall, flush, redirect, redirect_pc, im_rdata,
        input  im_addr, D_instr, D_pc, D_pc8, D_valid, D_exc_adel
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage with PC register and IF/ID pipeline
//                register. Branch/jump redirects resolved in decode have one
//                delay slot: the instruction fetched alongside the redirect
//                still enters IF/ID.
//  Parameters  : RESET_PC  - first fetch address after reset
//                IM_WORDS  - instruction memory size in 32-bit words
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous, active-low reset
//                bus       - fetch_if.master (control in, im_addr/D_* out)
//  Options     : FETCH_ADEL_CHECK_EN - when defined, misaligned or
//                out-of-range fetch addresses are flagged on D_exc_adel and
//                the fetched word is replaced by 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fetch_if.master     bus
);

    // ------------------------------------------------------------------------
    // State: F_pc and the IF/ID register. Nothing else is stored.
    // ------------------------------------------------------------------------
    logic [31:0] F_pc_q,       F_pc_d;
    logic [31:0] D_instr_q,    D_instr_d;
    logic [31:0] D_pc_q,       D_pc_d;
    logic [31:0] D_pc8_q,      D_pc8_d;
    logic        D_valid_q,    D_valid_d;
    logic        D_exc_adel_q, D_exc_adel_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;
    logic        w_adel;

    // Additions wrap modulo 2^32 by truncation to 32 bits.
    assign w_pc_plus4 = F_pc_q + 32'd4;
    assign w_pc_plus8 = F_pc_q + 32'd8;

`ifdef FETCH_ADEL_CHECK_EN
    // End of the instruction window, computed in 33 bits so a window that
    // reaches the top of the address space does not wrap to a small value.
    localparam logic [32:0] C_IM_END = {1'b0, RESET_PC} + (33'(IM_WORDS) * 33'd4);

    assign w_adel = (F_pc_q[1:0] != 2'b00)
                 || (F_pc_q < RESET_PC)
                 || ({1'b0, F_pc_q} >= C_IM_END);
`else
    assign w_adel = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic. The redirect target is taken by the PC independently
    // of flush, so a simultaneous redirect+flush both take effect.
    // ------------------------------------------------------------------------
    always_comb begin
        F_pc_d       = bus.redirect ? bus.redirect_pc : w_pc_plus4;
        D_pc_d       = F_pc_q;
        D_pc8_d      = w_pc_plus8;
        D_instr_d    = bus.im_rdata;
        D_valid_d    = 1'b1;
        D_exc_adel_d = 1'b0;

        if (bus.flush) begin
            // Bubble: the PC fields still track F_pc so the slot is traceable.
            D_instr_d    = 32'h0;
            D_valid_d    = 1'b0;
        end else if (w_adel) begin
            // A faulting fetch is a real slot carrying the exception flag;
            // the memory word is not trusted.
            D_instr_d    = 32'h0;
            D_exc_adel_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers. Stall freezes everything and masks redirect/flush.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            F_pc_q       <= RESET_PC;
            D_instr_q    <= 32'h0;
            D_pc_q       <= RESET_PC;
            D_pc8_q      <= RESET_PC + 32'd8;
            D_valid_q    <= 1'b0;
            D_exc_adel_q <= 1'b0;
        end else if (!bus.stall) begin
            F_pc_q       <= F_pc_d;
            D_instr_q    <= D_instr_d;
            D_pc_q       <= D_pc_d;
            D_pc8_q      <= D_pc8_d;
            D_valid_q    <= D_valid_d;
            D_exc_adel_q <= D_exc_adel_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.im_addr    = F_pc_q;
    assign bus.D_instr    = D_instr_q;
    assign bus.D_pc       = D_pc_q;
    assign bus.D_pc8      = D_pc8_q;
    assign bus.D_valid    = D_valid_q;
    assign bus.D_exc_adel = D_exc_adel_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. A reference PC model
//                pushes the expected IF/ID contents for every clock step into
//                a scoreboard queue; the entry is popped and compared after
//                the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] IM_LAST = 32'h0000_7000;   // RST_PC + 4*4096

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
        logic        exc;
    } d_t;

    logic    clk;
    logic    reset;
    fetch_if bus();

    int      n_checks;
    int      n_errors;

    d_t          sb[$];
    logic [31:0] m_pc;
    d_t          m_d;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .IM_WORDS (4096)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: content is a fixed function of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.im_rdata = imem(bus.im_addr);

    function automatic logic adel(input logic [31:0] a);
`ifdef FETCH_ADEL_CHECK_EN
        return (a[1:0] != 2'b00) || (a < RST_PC) || (a >= IM_LAST);
`else
        return 1'b0 && (a != 32'h0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RST_PC;
        m_d.instr = 32'h0;
        m_d.pc    = RST_PC;
        m_d.pc8   = RST_PC + 32'd8;
        m_d.valid = 1'b0;
        m_d.exc   = 1'b0;
        sb.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".im_addr"}, bus.im_addr,          RST_PC);
        chk({tag, ".instr"},   bus.D_instr,          32'h0);
        chk({tag, ".pc"},      bus.D_pc,             RST_PC);
        chk({tag, ".pc8"},     bus.D_pc8,            RST_PC + 32'd8);
        chk({tag, ".valid"},   32'(bus.D_valid),     32'd0);
        chk({tag, ".exc"},     32'(bus.D_exc_adel),  32'd0);
    endtask

    // One clock step: drive inputs, predict, clock, compare.
    task automatic step(input logic st, input logic fl, input logic rd,
                        input logic [31:0] rpc, input string tag);
        d_t e;
        bus.stall       = st;
        bus.flush       = fl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        if (!st) begin
            e.pc  = m_pc;
            e.pc8 = m_pc + 32'd8;
            if (fl) begin
                e.instr = 32'h0; e.valid = 1'b0; e.exc = 1'b0;
            end else if (adel(m_pc)) begin
                e.instr = 32'h0; e.valid = 1'b1; e.exc = 1'b1;
            end else begin
                e.instr = imem(m_pc); e.valid = 1'b1; e.exc = 1'b0;
            end
            m_d  = e;
            m_pc = rd ? rpc : m_pc + 32'd4;
        end
        sb.push_back(m_d);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".im_addr"}, bus.im_addr,         m_pc);
        chk({tag, ".instr"},   bus.D_instr,         e.instr);
        chk({tag, ".pc"},      bus.D_pc,            e.pc);
        chk({tag, ".pc8"},     bus.D_pc8,           e.pc8);
        chk({tag, ".valid"},   32'(bus.D_valid),    32'(e.valid));
        chk({tag, ".exc"},     32'(bus.D_exc_adel), 32'(e.exc));
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        reset           = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        model_reset();

        // Reset held across a clock edge.
        #12;
        chk_reset("rst");
        reset = 1'b1;

        // Sequential fetch, then a redirect with its delay slot.
        step(0, 0, 0, 32'h0,        "seq0");     // D_pc 3000
        step(0, 0, 0, 32'h0,        "seq1");     // D_pc 3004
        step(0, 0, 1, 32'h0000_3100,"redir");    // D_pc 3008 (delay slot)
        step(0, 0, 0, 32'h0,        "tgt");      // D_pc 3100

        // Stall with a redirect present: frozen, redirect ignored.
        step(1, 0, 1, 32'h0000_3300,"stall0");
        step(1, 1, 1, 32'h0000_3300,"stall1");
        step(0, 0, 0, 32'h0,        "resume");   // D_pc 3104

        // Flush together with redirect: bubble, then target.
        step(0, 1, 1, 32'h0000_3200,"flush");
        step(0, 0, 0, 32'h0,        "ftgt");     // D_pc 3200

        // Misaligned target, then wrap at the top of the address space.
        step(0, 0, 1, 32'h0000_3102,"mis_r");
        step(0, 0, 1, 32'hFFFF_FFFC,"mis");      // D_pc 3102
        step(0, 0, 0, 32'h0,        "top");      // D_pc FFFFFFFC, pc8 4
        step(0, 0, 1, 32'h0000_6FFC,"wrap");     // D_pc 0
        step(0, 0, 0, 32'h0,        "last");     // D_pc 6FFC (last word)
        step(0, 0, 0, 32'h0,        "past");     // D_pc 7000 (just beyond)

        // Reset pulsed between edges with a stall and redirect pending.
        bus.stall       = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_3300;
        #2;
        reset = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(posedge clk);
        #1;
        chk_reset("mid_hold");
        reset = 1'b1;
        model_reset();
        step(0, 0, 0, 32'h0,        "post0");    // D_pc 3000
        step(0, 0, 0, 32'h0,        "post1");    // D_pc 3004

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the first fetch address after reset.
REQ-002 Parameter IM_WORDS, default 4096, SHALL be the instruction-memory size in 32-bit words.
REQ-003 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-low (0 = reset).
REQ-005 stall  input  1  SHALL freeze the PC and the IF/ID register when 1 (driven by the hazard unit).
REQ-006 flush  input  1  SHALL load a bubble into IF/ID when 1 and stall is 0.
REQ-007 redirect  input  1  SHALL mean a branch or jump resolved in decode is taken.
REQ-008 redirect_pc  input  32  SHALL be the target address for a taken redirect.
REQ-009 im_addr  output  32  SHALL be the byte address currently fetched (F_pc).
REQ-010 im_rdata  input  32  SHALL be the instruction word at im_addr, returned combinationally in the same cycle.
REQ-011 D_instr  output  32  SHALL be the registered instruction presented to the decode controller.
REQ-012 D_pc  output  32  SHALL be the registered PC of D_instr.
REQ-013 D_pc8  output  32  SHALL equal D_pc+8, the link value for jal/jalr/bioal.
REQ-014 D_valid  output  1  SHALL be 1 when D_instr is a real fetched instruction and 0 for a bubble.
REQ-015 D_exc_adel  output  1  SHALL flag an instruction-fetch address error (see Configuration).

Function
REQ-016 F_pc SHALL be a 32-bit register; im_addr SHALL equal F_pc combinationally.
REQ-017 Next-PC SHALL be redirect_pc when redirect=1, otherwise F_pc+4; addition SHALL wrap modulo 2^32.
REQ-018 With stall=1, F_pc and all D_* registers SHALL hold, and redirect and flush SHALL be ignored that cycle.
REQ-019 With stall=0 and flush=0, IF/ID SHALL capture {im_rdata, F_pc, F_pc+8, valid=1} at each edge.
REQ-020 With stall=0 and flush=1, IF/ID SHALL capture {32'h0, F_pc, F_pc+8, valid=0}, and F_pc SHALL still advance per REQ-017.
REQ-021 Delay slot: a redirect SHALL NOT squash the instruction fetched in the same cycle; that instruction SHALL enter IF/ID normally.
REQ-022 Latency SHALL be exactly one cycle from F_pc to the matching D_pc; a redirect asserted in cycle n SHALL make F_pc=redirect_pc in cycle n+1.
REQ-023 Simultaneous redirect and flush with stall=0: both SHALL take effect, with the PC taking the target and IF/ID taking a bubble.
REQ-024 The only state SHALL be F_pc and the IF/ID register; there SHALL be no other FSM.

Reset
REQ-025 On reset=0, regardless of clk: F_pc=RESET_PC, D_instr=0, D_pc=RESET_PC, D_pc8=RESET_PC+8, D_valid=0, D_exc_adel=0.
REQ-026 Reset asserted mid-operation SHALL discard a pending redirect and any stall.
REQ-027 On release, the first edge SHALL fetch RESET_PC.

Configuration
REQ-028 Macro FETCH_ADEL_CHECK_EN defined: an address error SHALL be any F_pc[1:0]!=0 or any F_pc outside [RESET_PC, RESET_PC+4*IM_WORDS).
REQ-029 On an address error with FETCH_ADEL_CHECK_EN defined, IF/ID SHALL capture D_instr=0, D_valid=1 and D_exc_adel=1 instead of im_rdata.
REQ-030 Macro FETCH_ADEL_CHECK_EN undefined: D_exc_adel SHALL be constant 0, and im_rdata SHALL be captured unchecked.

Verification
REQ-031 Release reset, no stall, for 3 cycles -> D_pc sequence 3000, 3004, 3008, with D_pc8 = 3008, 300C, 3010 and D_valid=1.
REQ-032 redirect=1, redirect_pc=3100 while F_pc=3008 -> next D_pc=3008 (delay slot), then 3100.
REQ-033 stall=1 for 2 cycles together with redirect=1 -> F_pc and D_* frozen and redirect ignored; normal flow resumes after stall drops.
REQ-034 flush=1 with redirect=1 and target 3200 -> D_instr=0 and D_valid=0 for one cycle, then D_pc=3200.
REQ-035 reset pulsed low mid-run between edges -> outputs immediately at the REQ-025 values.
REQ-036 With FETCH_ADEL_CHECK_EN defined, redirect_pc=3102 -> D_exc_adel=1 and D_instr=0; without the macro, D_exc_adel stays 0.
